// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
//   state_t      : sequencer states
//   REQ0 / REQ1  : requester ids used for owner / winner encoding
//   DEF_*        : default RAM geometry (64 x 8)
package spram_arb_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_t;
endpackage

// File: rtl/spram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req    : request vector, bit i = requester i
//   last   : requester granted most recently
//   valid  : at least one request present
//   winner : chosen requester (meaningful only while valid)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  assign valid = |req;
  // On a tie the requester that did not win last time goes; otherwise
  // whichever one is asking (req[1] alone selects 1, req[0] alone selects 0).
  assign winner = (&req) ? ~last : req[1];
endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter / sequencer in front of one 64x8 single-port RAM.
// Serialises read and write commands from two requesters onto the RAM
// port, captures the synchronous read data and hands it back to the
// requester that issued the read.
//   clk, rst                    : clock, async active-high reset
//   req_x/we_x/addr_x/wdata_x   : requester x command (held until gnt_x)
//   gnt_x                       : one-cycle grant, high while command is on the RAM
//   rvalid_x/rdata_x            : one-cycle read return pulse + data
//   ram_data/ram_addr/ram_we    : RAM command port
//   ram_q                       : RAM read data, valid the cycle after addr sampled
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);
  // Per-requester inputs gathered into packed vectors so the winner can index them.
  logic [1:0]             req_v;
  logic [1:0]             we_v;
  logic [1:0][ADDR_W-1:0] addr_v;
  logic [1:0][DATA_W-1:0] wdata_v;

  assign req_v   = {req_1, req_0};
  assign we_v    = {we_1, we_0};
  assign addr_v  = {addr_1, addr_0};
  assign wdata_v = {wdata_1, wdata_0};

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   owner_q, owner_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_data_q, ram_data_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]             rvalid_q, rvalid_d;

  logic pick_valid, pick_winner;

  rr_pick2 u_pick (
    .req    (req_v),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= REQ1;
      owner_q    <= REQ0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // The RAM command is registered here so it sits on the port for
          // the whole ACCESS cycle; ram_we_q is therefore high only in ACCESS.
          owner_d    = pick_winner;
          last_d     = pick_winner;
          ram_we_d   = we_v[pick_winner];
          ram_addr_d = addr_v[pick_winner];
          ram_data_d = wdata_v[pick_winner];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // ram_we_q doubles as the command type for the cycle it was granted.
        state_d = ram_we_q ? IDLE : RDCAP;
      end
      RDCAP: begin
        rdata_d[owner_q]  = ram_q;
        rvalid_d[owner_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_0    = (state_q == ACCESS) && (owner_q == REQ0);
  assign gnt_1    = (state_q == ACCESS) && (owner_q == REQ1);
  assign rvalid_0 = rvalid_q[REQ0];
  assign rvalid_1 = rvalid_q[REQ1];
  assign rdata_0  = rdata_q[REQ0];
  assign rdata_1  = rdata_q[REQ1];
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1, ram_we;
  logic [DW-1:0] rdata_0, rdata_1, ram_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;

  spram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // single-port RAM: synchronous write, registered read
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model + scoreboard
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_d0[$], exp_d1[$];
  int            exp_c0[$], exp_c1[$];
  int            order[$];
  int            checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one access from requester r; call #1 after a posedge.
  // On grant, the reference memory is updated or the read result queued.
  task automatic access(input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gc, output int lat);
    int ic;
    bit got;
    ic = cyc;
    if (r == 0) begin req_0 = 1; we_0 = we; addr_0 = a; wdata_0 = d; end
    else        begin req_1 = 1; we_1 = we; addr_1 = a; wdata_1 = d; end
    got = 0;
    gc  = -1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      if ((r == 0) ? gnt_0 : gnt_1) got = 1;
    end
    chk($sformatf("grant_seen_r%0d", r), {31'd0, got}, 1);
    if (got) begin
      gc = cyc;
      order.push_back(r);
      if (we) ref_mem[a] = d;
      else if (r == 0) begin exp_d0.push_back(ref_mem[a]); exp_c0.push_back(gc + 2); end
      else             begin exp_d1.push_back(ref_mem[a]); exp_c1.push_back(gc + 2); end
    end
    lat = gc - ic;
    if (r == 0) req_0 = 0; else req_1 = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    settle(2);
    rst = 0;
  endtask

  // monitor: decoupled checking of returned data and invariants
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_exclusive", {31'd0, gnt_0 & gnt_1}, 0);
      chk("rvalid_exclusive", {31'd0, rvalid_0 & rvalid_1}, 0);
      chk("ram_we_only_when_granted", {31'd0, ram_we & ~(gnt_0 | gnt_1)}, 0);
      if (rvalid_0) begin
        if (exp_d0.size() == 0) chk("rvalid_0_unexpected", 1, 0);
        else begin
          chk("rdata_0", {24'd0, rdata_0}, {24'd0, exp_d0.pop_front()});
          chk("rvalid_0_cycle", cyc, exp_c0.pop_front());
        end
      end
      if (rvalid_1) begin
        if (exp_d1.size() == 0) chk("rvalid_1_unexpected", 1, 0);
        else begin
          chk("rdata_1", {24'd0, rdata_1}, {24'd0, exp_d1.pop_front()});
          chk("rvalid_1_cycle", cyc, exp_c1.pop_front());
        end
      end
    end
  end

  initial begin
    int g0, g1, l0, l1, diffs;
    bit got;
    logic [DW-1:0] snap [64];
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // reset values
    settle(2);
    chk("rst_gnt", {30'd0, gnt_1, gnt_0}, 0);
    chk("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_ram_addr", {26'd0, ram_addr}, 0);
    chk("rst_ram_data", {24'd0, ram_data}, 0);
    chk("rst_rdata", {16'd0, rdata_1, rdata_0}, 0);
    rst = 0;
    settle(1);

    // requester 0 writes then reads back, uncontested
    for (int i = 0; i < 3; i++) begin
      access(0, 1, AW'(i), DW'(i + 1), g0, l0);
      chk("wr_gnt_latency", l0, 1);
      settle(2);
    end
    for (int i = 0; i < 3; i++) begin
      access(0, 0, AW'(i), '0, g0, l0);
      chk("rd_gnt_latency", l0, 1);
      settle(3);
    end

    // simultaneous writes from reset: requester 0 first, 1 two cycles later
    do_reset();
    order.delete();
    fork
      access(0, 1, 6'd5, 8'hAA, g0, l0);
      access(1, 1, 6'd6, 8'h55, g1, l1);
    join
    chk("tie_first_winner", order[0], 0);
    chk("tie_second_gap", g1 - g0, 2);
    settle(1);
    access(0, 0, 6'd5, '0, g0, l0);
    settle(3);
    access(1, 0, 6'd6, '0, g1, l1);
    settle(3);

    // both hold req reading addr 1: grants alternate, 8 total
    order.delete();
    fork
      repeat (4) access(0, 0, 6'd1, '0, g0, l0);
      repeat (4) access(1, 0, 6'd1, '0, g1, l1);
    join
    chk("alt_count", order.size(), 8);
    chk("alt_first", order[0], 0);
    for (int i = 1; i < order.size(); i++)
      chk($sformatf("alt_%0d", i), order[i], 1 - order[i-1]);
    settle(3);

    // requester 1 writes, requester 0 reads it back
    access(1, 1, 6'd1, 8'h04, g1, l1);
    settle(1);
    access(0, 0, 6'd1, '0, g0, l0);
    settle(3);

    // reset during RDCAP: no rvalid, outputs cleared, tie then goes to 0.
    // Requester 0 wins this read, so without reset the next tie would go to 1.
    req_0 = 1; we_0 = 0; addr_0 = 6'd2;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = gnt_0;
    end
    chk("rdcap_read_granted", {31'd0, got}, 1);
    req_0 = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("midrst_gnt", {30'd0, gnt_1, gnt_0}, 0);
    chk("midrst_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
    chk("midrst_ram_we", {31'd0, ram_we}, 0);
    chk("midrst_ram_addr", {26'd0, ram_addr}, 0);
    chk("midrst_ram_data", {24'd0, ram_data}, 0);
    chk("midrst_rdata", {16'd0, rdata_1, rdata_0}, 0);
    settle(2);
    rst = 0;
    settle(2);
    order.delete();
    fork
      access(0, 0, 6'd0, '0, g0, l0);
      access(1, 0, 6'd2, '0, g1, l1);
    join
    chk("postrst_tie_winner", order[0], 0);
    settle(4);

    // idle: no writes, RAM untouched, then read back addr 0
    for (int i = 0; i < 64; i++) snap[i] = mem[i];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ram_we", {31'd0, ram_we}, 0);
    end
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== snap[i]) diffs++;
    chk("idle_ram_unchanged", diffs, 0);
    @(posedge clk); #1;
    access(0, 0, 6'd0, '0, g0, l0);
    settle(3);
    chk("addr0_model", {24'd0, ref_mem[0]}, 32'h01);

    // randomized concurrent traffic
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        access(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), g0, l0);
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        access(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), g1, l1);
      end
    join
    settle(6);
    chk("drain_q0", exp_d0.size(), 0);
    chk("drain_q1", exp_d1.size(), 0);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final_ram_vs_model", diffs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester round-robin arbiter and sequencer for the 64x8 single-port RAM. It serialises write and read commands from requesters 0 and 1 onto the RAM's single data/addr/we port and captures the synchronous read data. It returns that data to the owning requester with a one-cycle valid pulse. It sits between two client blocks and one `single_port_ram` instance.

## Interface
- `DATA_W`, 8, RAM word width
- `ADDR_W`, 6, RAM address width (depth 2^ADDR_W)

Ports:
- `clk`  in  1  rising-edge clock, shared with the RAM
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `req_0` / `req_1`  in  1  access request, held until grant
- `we_0` / `we_1`  in  1  1 = write, 0 = read
- `addr_0` / `addr_1`  in  ADDR_W  access address
- `wdata_0` / `wdata_1`  in  DATA_W  write data
- `gnt_0` / `gnt_1`  out  1  one-cycle grant pulse
- `rvalid_0` / `rvalid_1`  out  1  one-cycle read-data-valid pulse
- `rdata_0` / `rdata_1`  out  DATA_W  read data, meaningful only while the matching rvalid is high
- `ram_data`  out  DATA_W  to RAM `data`
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_we`  out  1  to RAM `we`
- `ram_q`  in  DATA_W  from RAM `q`; valid the cycle after the read address was sampled

## Operation
- FSM states:
  - IDLE: sample `req_0`/`req_1`; if either is set, latch the winner's we/addr/wdata into the `ram_*` registers, set `owner`, and go to ACCESS.
  - ACCESS: present the command to the RAM for exactly one cycle and assert `gnt_owner`. A write goes to IDLE; a read goes to RDCAP.
  - RDCAP: register `ram_q` into `rdata_owner`, then go to IDLE. `rvalid_owner` is high during the following cycle.
- Round-robin arbitration:
  - `last` register, reset value 1, so requester 0 wins the first tie.
  - Both requests set: grant `!last`.
  - Single request: grant it.
  - `last` is updated to the winner on entry to ACCESS.
- Requests are sampled only in IDLE. A requester must keep `req`, `we`, `addr` and `wdata` stable until it sees its `gnt`. It must drop `req` by the cycle after `gnt` unless it wants another access.
- `ram_we` is 1 only in ACCESS with a write command. It is 0 in all other states, so the RAM is never written outside a granted write.
- `ram_addr` and `ram_data` hold their last values outside ACCESS; their value is don't-care to the RAM when `ram_we` = 0.
- `rdata_x` holds its last captured value; only the owner's `rdata` is updated.

## Timing
- Write: request sampled in cycle N → `gnt` and `ram_we` high in N+1 → RAM written on the N+1/N+2 edge → next arbitration in N+2. Throughput is one write per 2 cycles.
- Read: request in N → `gnt` in N+1 → `ram_q` valid in N+2 (captured at its end) → `rvalid`/`rdata` in N+3. IDLE re-arbitrates in N+3 in parallel with `rvalid`. Throughput is one read per 3 cycles.
- Reset values:
  - state IDLE, `last` = 1, `owner` = 0
  - all `gnt`, `rvalid`, `ram_we` = 0
  - `ram_addr`, `ram_data`, `rdata_0`, `rdata_1` = 0
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronous). An in-flight read produces no `rvalid`. An in-flight write may or may not land, depending on whether the clock edge precedes reset.
- Both requests in the same IDLE cycle: exactly one `gnt`. The loser is served at the next IDLE if it still holds `req`.
- A requester that keeps `req` high after its grant is re-requesting. Under contention it alternates with the other requester; if alone, it is granted back-to-back.
- `gnt_0` and `gnt_1` are never high together; the same holds for `rvalid_0` and `rvalid_1`.

## Structure
- Package `spram_arb_pkg`:
  - state enum {IDLE, ACCESS, RDCAP}
  - requester-id constants REQ0 = 0, REQ1 = 1
  - default DATA_W/ADDR_W localparams
- Natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker (inputs `req[1:0]` and `last`; outputs `valid` and `winner`).
- The RAM is not instantiated inside; the bench wires `spram_arbiter` to `single_port_ram`.

## Test plan
- Requester 0 writes 0x01@0, 0x02@1, 0x03@2, then reads 0, 1, 2 → `rvalid_0` pulses with `rdata_0` = 0x01, 0x02, 0x03, each 3 cycles after its request; `rvalid_1` stays 0.
- Both requesters write in the same cycle (req 0: 0xAA@5, req 1: 0x55@6) from reset → `gnt_0` first, `gnt_1` 2 cycles later; subsequent reads return 0xAA@5 and 0x55@6.
- Both requesters hold `req` high reading addr 1 → grants alternate 0, 1, 0, 1; no starvation across 8 grants.
- Requester 1 writes 0x04@1, then requester 0 reads 1 → `rdata_0` = 0x04.
- Assert `rst` during RDCAP of a read → no `rvalid`, all outputs 0; the first post-reset tie goes to requester 0.
- Idle with no requests for 10 cycles → `ram_we` = 0 throughout and RAM contents unchanged (read back 0x01@0).
